// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock: state encodings and digit strobe codes.
package lock_pkg;

  typedef logic [2:0] lock_state_t;

  localparam lock_state_t ST_IDLE    = 3'd0;
  localparam lock_state_t ST_ENTRY   = 3'd1;
  localparam lock_state_t ST_OPEN    = 3'd2;
  localparam lock_state_t ST_PROG    = 3'd3;
  localparam lock_state_t ST_LOCKOUT = 3'd4;

  localparam logic [1:0] DIGIT_ONE  = 2'b10;
  localparam logic [1:0] DIGIT_ZERO = 2'b01;

  // Only the two one-hot strobes are digits; 2'b00 and 2'b11 are both "nothing".
  function automatic logic digit_valid(input logic [1:0] d);
    return (d == DIGIT_ONE) || (d == DIGIT_ZERO);
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counter for the lockout period: load presets it, count decrements it, done flags zero.
module lockout_timer #(
  parameter int WIDTH      = 9,
  parameter int LOAD_VALUE = 299
) (
  input  logic clk,
  input  logic srst,
  input  logic load,
  input  logic count,
  output logic done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= WIDTH'(LOAD_VALUE);
    end else if (count && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/combination_lock.sv
// Serial-entry combination lock with attempt limiting, timed lockout and in-field reprogramming.
module combination_lock
  import lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 4,
  parameter int                  MAX_ATTEMPTS   = 3,
  parameter int                  LOCKOUT_CYCLES = 300,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1001
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic [1:0]                        digit,
  input  logic                              relock,
  input  logic                              prog,
  output logic                              unlocked,
  output logic                              locked_out,
  output logic                              programming,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_count,
  output logic [3:0]                        attempts_left
);

  localparam int              CW            = $clog2(CODE_LEN + 1);
  localparam int              TW            = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [3:0]      ATTEMPTS_FULL = 4'(MAX_ATTEMPTS);
  localparam logic [CW-1:0]   LAST_COUNT    = CW'(CODE_LEN);

  typedef logic [CODE_LEN-1:0] code_t;

  lock_state_t state_reg, state_next;
  code_t       code_reg, code_next;
  code_t       entry_reg, entry_next;
  logic [CW-1:0] count_reg, count_next;
  logic [3:0]  attempts_reg, attempts_next;
  logic        unlocked_reg, locked_out_reg, programming_reg;

  logic        timer_load;
  logic        timer_done;
  logic        is_digit;
  code_t       entry_base;
  code_t       entry_shift;
  logic [CW-1:0] count_base;
  logic [CW-1:0] count_inc;
  logic        last_digit;

  lockout_timer #(
    .WIDTH      (TW),
    .LOAD_VALUE (LOCKOUT_CYCLES - 1)
  ) u_lockout_timer (
    .clk   (clk),
    .srst  (srst),
    .load  (timer_load),
    .count (state_reg == ST_LOCKOUT),
    .done  (timer_done)
  );

  // IDLE always starts a fresh entry, so shift from zero regardless of leftovers.
  assign is_digit    = digit_valid(digit);
  assign entry_base  = (state_reg == ST_IDLE) ? '0 : entry_reg;
  assign count_base  = (state_reg == ST_IDLE) ? '0 : count_reg;
  assign entry_shift = (entry_base << 1) | code_t'(digit == DIGIT_ONE);
  assign count_inc   = count_base + 1'b1;
  assign last_digit  = (count_inc == LAST_COUNT);

  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    entry_next    = entry_reg;
    count_next    = count_reg;
    attempts_next = attempts_reg;
    timer_load    = 1'b0;

    case (state_reg)
      ST_IDLE, ST_ENTRY: begin
        if (is_digit) begin
          if (last_digit) begin
            entry_next = '0;
            count_next = '0;
            if (entry_shift == code_reg) begin
              state_next    = ST_OPEN;
              attempts_next = ATTEMPTS_FULL;
            end else if (attempts_reg <= 4'd1) begin
              state_next    = ST_LOCKOUT;
              attempts_next = 4'd0;
              timer_load    = 1'b1;
            end else begin
              state_next    = ST_IDLE;
              attempts_next = attempts_reg - 4'd1;
            end
          end else begin
            state_next = ST_ENTRY;
            entry_next = entry_shift;
            count_next = count_inc;
          end
        end
      end

      ST_OPEN: begin
        if (relock) begin
          state_next = ST_IDLE;
        end else if (prog) begin
          state_next = ST_PROG;
          entry_next = '0;
          count_next = '0;
        end
      end

      ST_PROG: begin
        if (relock) begin
          state_next = ST_IDLE;
          entry_next = '0;
          count_next = '0;
        end else if (is_digit) begin
          if (last_digit) begin
            state_next = ST_OPEN;
            code_next  = entry_shift;
            entry_next = '0;
            count_next = '0;
          end else begin
            entry_next = entry_shift;
            count_next = count_inc;
          end
        end
      end

      ST_LOCKOUT: begin
        if (timer_done) begin
          state_next    = ST_IDLE;
          attempts_next = ATTEMPTS_FULL;
          entry_next    = '0;
          count_next    = '0;
        end
      end

      default: begin
        state_next    = ST_IDLE;
        entry_next    = '0;
        count_next    = '0;
        attempts_next = ATTEMPTS_FULL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg       <= ST_IDLE;
      code_reg        <= DEFAULT_CODE;
      entry_reg       <= '0;
      count_reg       <= '0;
      attempts_reg    <= ATTEMPTS_FULL;
      unlocked_reg    <= 1'b0;
      locked_out_reg  <= 1'b0;
      programming_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      code_reg        <= code_next;
      entry_reg       <= entry_next;
      count_reg       <= count_next;
      attempts_reg    <= attempts_next;
      unlocked_reg    <= (state_next == ST_OPEN);
      locked_out_reg  <= (state_next == ST_LOCKOUT);
      programming_reg <= (state_next == ST_PROG);
    end
  end

  assign unlocked      = unlocked_reg;
  assign locked_out    = locked_out_reg;
  assign programming   = programming_reg;
  assign digit_count   = count_reg;
  assign attempts_left = attempts_reg;

endmodule

// File: tb/tb_combination_lock.sv
// Randomized and directed checks of combination_lock against a queue-based behavioural model.
module tb_combination_lock;

  localparam int N_DIG   = 4;
  localparam int MAX_ATT = 3;
  localparam int LOCK_CY = 300;
  localparam int DEF_CODE = 9;

  logic       clk = 1'b0;
  logic       srst = 1'b0;
  logic [1:0] digit = 2'b00;
  logic       relock = 1'b0;
  logic       prog = 1'b0;
  logic       unlocked, locked_out, programming;
  logic [2:0] digit_count;
  logic [3:0] attempts_left;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: digits so far, stored code as an integer, lockout cycles remaining.
  int m_buf[$];
  int m_code;
  int m_attempts;
  int m_lock_rem;
  bit m_open;
  bit m_prog;

  combination_lock #(
    .CODE_LEN       (N_DIG),
    .MAX_ATTEMPTS   (MAX_ATT),
    .LOCKOUT_CYCLES (LOCK_CY),
    .DEFAULT_CODE   (4'b1001)
  ) dut (
    .clk           (clk),
    .srst          (srst),
    .digit         (digit),
    .relock        (relock),
    .prog          (prog),
    .unlocked      (unlocked),
    .locked_out    (locked_out),
    .programming   (programming),
    .digit_count   (digit_count),
    .attempts_left (attempts_left)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int buf_value();
    int v = 0;
    foreach (m_buf[i]) v = v * 2 + m_buf[i];
    return v;
  endfunction

  task automatic model_step(input logic [1:0] d, input bit rl, input bit pg, input bit rst);
    bit valid;
    int v;
    valid = (d == 2'b10) || (d == 2'b01);
    if (rst) begin
      m_buf.delete();
      m_code = DEF_CODE; m_attempts = MAX_ATT; m_lock_rem = 0;
      m_open = 0; m_prog = 0;
    end else if (m_lock_rem > 0) begin
      m_lock_rem--;
      if (m_lock_rem == 0) m_attempts = MAX_ATT;
    end else if (m_open) begin
      if (rl) m_open = 0;
      else if (pg) begin m_open = 0; m_prog = 1; m_buf.delete(); end
    end else if (m_prog) begin
      if (rl) begin m_prog = 0; m_buf.delete(); end
      else if (valid) begin
        m_buf.push_back(d == 2'b10);
        if (m_buf.size() == N_DIG) begin
          m_code = buf_value(); m_buf.delete();
          m_prog = 0; m_open = 1;
          $display("program new code %0d", m_code);
        end
      end
    end else if (valid) begin
      m_buf.push_back(d == 2'b10);
      if (m_buf.size() == N_DIG) begin
        v = buf_value(); m_buf.delete();
        if (v == m_code) begin
          m_open = 1; m_attempts = MAX_ATT;
        end else begin
          m_attempts--;
          if (m_attempts == 0) m_lock_rem = LOCK_CY;
        end
        $display("entry %0d vs code %0d -> open=%0d attempts=%0d lockout=%0d",
                 v, m_code, m_open, m_attempts, m_lock_rem > 0);
      end
    end
  endtask

  task automatic apply(input logic [1:0] d, input bit rl, input bit pg, input bit rst);
    digit = d; relock = rl; prog = pg; srst = rst;
    @(posedge clk);
    model_step(d, rl, pg, rst);
    #1;
    check_val("unlocked", unlocked, m_open);
    check_val("locked_out", locked_out, m_lock_rem > 0);
    check_val("programming", programming, m_prog);
    check_val("digit_count", digit_count, m_buf.size());
    check_val("attempts_left", attempts_left, m_attempts);
  endtask

  task automatic dig(input bit b);
    apply(b ? 2'b10 : 2'b01, 0, 0, 0);
  endtask

  task automatic enter(input int code);
    for (int i = N_DIG - 1; i >= 0; i--) dig(((code >> i) & 1) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(2'b00, 0, 0, 0);
  endtask

  task automatic do_reset();
    apply(2'b00, 0, 0, 1);
    apply(2'b00, 0, 0, 0);
  endtask

  int lock_len;

  initial begin
    // Reset state
    do_reset();
    check_val("reset_attempts", attempts_left, 3);
    check_val("reset_unlocked", unlocked, 0);

    // Default code opens one cycle after the fourth digit
    $display("scenario: default code unlock");
    enter(4'b1001);
    check_val("default_unlock", unlocked, 1);
    check_val("default_attempts", attempts_left, 3);
    apply(2'b00, 1, 0, 0);

    // Three wrong entries, then exactly LOCK_CY cycles of lockout with digits ignored
    $display("scenario: lockout");
    enter(4'b1111);
    check_val("wrong1_attempts", attempts_left, 2);
    enter(4'b1111);
    check_val("wrong2_attempts", attempts_left, 1);
    enter(4'b1111);
    lock_len = 0;
    for (int i = 0; i < LOCK_CY + 20 && locked_out === 1'b1; i++) begin
      lock_len++;
      apply(2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 0);
    end
    check_val("lockout_length", lock_len, LOCK_CY);
    check_val("post_lockout_attempts", attempts_left, 3);

    // Reprogram, relock, old code fails, new code opens
    $display("scenario: reprogram");
    enter(4'b1001);
    apply(2'b00, 0, 1, 0);
    check_val("prog_flag", programming, 1);
    enter(4'b0110);
    check_val("prog_back_open", unlocked, 1);
    apply(2'b00, 1, 0, 0);
    enter(4'b1001);
    check_val("old_code_attempts", attempts_left, 2);
    enter(4'b0110);
    check_val("new_code_unlock", unlocked, 1);

    // Reset restores the default code
    do_reset();
    $display("scenario: interleaved idle strobes");
    apply(2'b10, 0, 0, 0);
    apply(2'b11, 0, 0, 0);
    check_val("count_ignores_11", digit_count, 1);
    apply(2'b01, 0, 0, 0);
    apply(2'b00, 0, 0, 0);
    apply(2'b01, 0, 0, 0);
    apply(2'b11, 0, 0, 0);
    apply(2'b10, 0, 0, 0);
    check_val("interleave_unlock", unlocked, 1);

    // Reset mid-entry and mid-lockout
    $display("scenario: reset mid-entry and mid-lockout");
    apply(2'b00, 1, 0, 0);
    dig(1); dig(0);
    apply(2'b00, 0, 0, 1);
    check_val("rst_mid_entry_count", digit_count, 0);
    enter(4'b0000); enter(4'b0000); enter(4'b0000);
    idle(50);
    apply(2'b00, 0, 0, 1);
    check_val("rst_mid_lockout", locked_out, 0);
    enter(4'b1001);
    check_val("rst_code_restored", unlocked, 1);

    // Relock wins over program; relock in PROG aborts without changing code
    $display("scenario: relock priority and prog abort");
    apply(2'b00, 1, 1, 0);
    check_val("relock_wins_prog", programming, 0);
    enter(4'b1001);
    apply(2'b00, 0, 1, 0);
    dig(0); dig(0);
    apply(2'b10, 1, 0, 0);
    enter(4'b1001);
    check_val("prog_abort_code_kept", unlocked, 1);

    // Randomized phase
    $display("scenario: random");
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 5))
        0, 1: enter(m_code);
        2: enter(int'($urandom_range(0, 15)));
        3: for (int k = 0; k < 8; k++)
             apply(2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 199) == 0);
        4: apply(2'b00, 0, 1, 0);
        default: apply(2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0, 0, 0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/combination_lock.md
COMBINATION_LOCK -- requirements
Module: combination_lock

Interface
REQ-001 Parameter CODE_LEN, default 4: number of digits per code entry (1..16).
REQ-002 Parameter MAX_ATTEMPTS, default 3: consecutive wrong entries that trigger lockout (1..15).
REQ-003 Parameter LOCKOUT_CYCLES, default 300: lockout duration in clock cycles (>=1).
REQ-004 Parameter DEFAULT_CODE, default 4'b1001, width CODE_LEN: code loaded at reset; first digit entered = MSB.
REQ-005 Clock  input  1  single clock, all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-high.
REQ-007 Input  input  2  digit strobe: 2'b10 = digit 1, 2'b01 = digit 0, 2'b00/2'b11 = no digit; sampled every cycle.
REQ-008 Relock  input  1  in OPEN, return to IDLE.
REQ-009 Program  input  1  in OPEN, start entry of a new code.
REQ-010 Unlocked  output  1  high only in OPEN.
REQ-011 Locked_Out  output  1  high only in LOCKOUT.
REQ-012 Programming  output  1  high only in PROG.
REQ-013 Digit_Count  output  clog2(CODE_LEN+1)  digits accepted in the current entry.
REQ-014 Attempts_Left  output  4  MAX_ATTEMPTS minus consecutive wrong entries.

Function
REQ-015 States SHALL be IDLE, ENTRY, OPEN, PROG, LOCKOUT; all outputs registered.
REQ-016 Each cycle with a valid digit (10/01) SHALL shift that digit into a CODE_LEN-bit entry register and increment Digit_Count; no-digit cycles SHALL change nothing.
REQ-017 IDLE: first valid digit SHALL move to ENTRY with Digit_Count=1 (CODE_LEN=1 evaluates immediately per REQ-018).
REQ-018 On the cycle the CODE_LEN-th digit is accepted, the full entry SHALL be compared to the stored code; Unlocked/Locked_Out update on the following edge (latency 1 cycle after last digit).
REQ-019 Match: go to OPEN, Digit_Count=0, Attempts_Left=MAX_ATTEMPTS.
REQ-020 Mismatch: decrement Attempts_Left; if it reaches 0 go to LOCKOUT, else go to IDLE, Digit_Count=0 in both cases.
REQ-021 A wrong digit SHALL NOT abort entry early; all CODE_LEN digits are always consumed.
REQ-022 LOCKOUT: all digits, Relock and Program ignored; a down-counter loaded with LOCKOUT_CYCLES-1 on entry SHALL expire to IDLE with Attempts_Left=MAX_ATTEMPTS, so Locked_Out is high exactly LOCKOUT_CYCLES cycles.
REQ-023 OPEN: digits ignored; Relock -> IDLE; Program -> PROG; Relock and Program both high: Relock wins.
REQ-024 PROG: CODE_LEN valid digits SHALL be collected; on the last digit the stored code SHALL be replaced and state returns to OPEN; Relock in PROG aborts to IDLE, stored code unchanged.
REQ-025 Input 2'b11 SHALL be ignored in every state and SHALL NOT count as a digit.
REQ-026 Unused/illegal state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-027 Reset high SHALL, on the next edge, force IDLE, stored code=DEFAULT_CODE, entry register=0, Digit_Count=0, Attempts_Left=MAX_ATTEMPTS, lockout counter=0, Unlocked=Locked_Out=Programming=0.
REQ-028 Reset SHALL take priority over all inputs in any state, including mid-entry, mid-PROG and mid-LOCKOUT.

Structure
REQ-029 State encoding typedef and digit encodings (DIGIT_ONE=2'b10, DIGIT_ZERO=2'b01) SHALL live in shared package lock_pkg.
REQ-030 Lockout timer SHALL be a sub-module lockout_timer (load, count, done); remaining logic in combination_lock.

Verification
REQ-031 Defaults, after reset enter 1,0,0,1 -> Unlocked=1 one cycle after fourth digit, Attempts_Left=3.
REQ-032 Enter 1,1,1,1 three times -> Attempts_Left 2,1 then Locked_Out=1 for exactly 300 cycles, digits ignored, then IDLE with Attempts_Left=3.
REQ-033 Unlock, Program, enter 0,1,1,0 -> OPEN; Relock; 1,0,0,1 fails (Attempts_Left=2); 0,1,1,0 unlocks.
REQ-034 Digits interleaved with 2'b00/2'b11 cycles (1,11,0,00,0,1) -> unlock; Digit_Count never counts 11.
REQ-035 Reset asserted after 2 digits and again mid-LOCKOUT -> all outputs at reset values next cycle, code restored to 1001.
REQ-036 Relock and Program asserted together in OPEN -> IDLE, Programming stays 0.
